// File: rtl/assertion_result_collector.sv
// Collects one assertion checker's pass/fail/active strobes into saturating counters,
// a first-failure timestamp, a failure-timestamp FIFO with a valid/ready drain, and a status FSM.
module assertion_result_collector #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             assertion_pass,
    input  logic             assertion_fail,
    input  logic             assertion_active,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] active_cycles,
    output logic             first_fail_valid,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             log_valid,
    output logic [TS_W-1:0]  log_ts,
    input  logic             log_ready,
    output logic             log_overflow,
    output logic             conflict,
    output logic [1:0]       status
);
    localparam int unsigned AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10,
        ST_OVFL = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, act_q, act_d;
    logic              ffv_q, ffv_d;
    logic [TS_W-1:0]   ffts_q, ffts_d;
    logic [TS_W-1:0]   mem_q [LOG_DEPTH];
    logic [TS_W-1:0]   mem_d [LOG_DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic              log_valid_q, log_valid_d;
    logic [TS_W-1:0]   log_ts_q, log_ts_d;
    logic              ovf_q, ovf_d, conflict_q, conflict_d;

    logic              smp_pass, smp_fail, smp_act;
    logic              pop, full, push, ovf_evt;

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        act_d      = act_q;
        ffv_d      = ffv_q;
        ffts_d     = ffts_q;
        mem_d      = mem_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        occ_d      = occ_q;
        ovf_d      = ovf_q;
        conflict_d = conflict_q;

        smp_pass = enable & assertion_pass;
        smp_fail = enable & assertion_fail;
        smp_act  = enable & assertion_active;
        pop      = (occ_q != '0) & log_ready;
        full     = (occ_q == OW'(LOG_DEPTH));
        push     = smp_fail & (~full | pop);
        ovf_evt  = smp_fail & full & ~pop;

        if (enable) ts_d = ts_q + TS_W'(1);

        if (clear) begin
            // Clear discards this cycle's strobes and pops; only ts keeps running.
            pass_d     = '0;
            fail_d     = '0;
            act_d      = '0;
            ffv_d      = 1'b0;
            ffts_d     = '0;
            rd_d       = '0;
            wr_d       = '0;
            occ_d      = '0;
            ovf_d      = 1'b0;
            conflict_d = 1'b0;
            state_d    = enable ? ST_RUN : ST_IDLE;
        end else begin
            if (smp_pass) pass_d = sat_inc(pass_q);
            if (smp_fail) fail_d = sat_inc(fail_q);
            if (smp_act)  act_d  = sat_inc(act_q);
            if (smp_pass & smp_fail) conflict_d = 1'b1;
            if (smp_fail & ~ffv_q) begin
                ffv_d  = 1'b1;
                ffts_d = ts_q;
            end
            if (push) begin
                mem_d[wr_q] = ts_q;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            occ_d = occ_q + OW'(push) - OW'(pop);

            if (ovf_evt) begin
                ovf_d   = 1'b1;
                state_d = ST_OVFL;
            end else begin
                case (state_q)
                    ST_IDLE: if (enable) state_d = ST_RUN;
                    ST_RUN: begin
                        if (smp_fail)     state_d = ST_FAIL;
                        else if (!enable) state_d = ST_IDLE;
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        // Head is registered from next-state storage so log_ts lines up with log_valid.
        log_valid_d = (occ_d != '0);
        log_ts_d    = log_valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ts_q        <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            act_q       <= '0;
            ffv_q       <= 1'b0;
            ffts_q      <= '0;
            for (int i = 0; i < int'(LOG_DEPTH); i++) mem_q[i] <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            occ_q       <= '0;
            log_valid_q <= 1'b0;
            log_ts_q    <= '0;
            ovf_q       <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            act_q       <= act_d;
            ffv_q       <= ffv_d;
            ffts_q      <= ffts_d;
            mem_q       <= mem_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            occ_q       <= occ_d;
            log_valid_q <= log_valid_d;
            log_ts_q    <= log_ts_d;
            ovf_q       <= ovf_d;
            conflict_q  <= conflict_d;
        end
    end

    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign active_cycles    = act_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_ts    = ffts_q;
    assign log_valid        = log_valid_q;
    assign log_ts           = log_ts_q;
    assign log_overflow     = ovf_q;
    assign conflict         = conflict_q;
    assign status           = state_q;

endmodule

// File: tb/tb_assertion_result_collector.sv
// Random plus directed stimulus for assertion_result_collector, checked against a queue-based model.
module tb_assertion_result_collector;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SMALL_W = 4;
    localparam int unsigned TS_W    = 32;
    localparam int unsigned DEPTH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, clear = 1'b0, a_pass = 1'b0, a_fail = 1'b0, a_act = 1'b0, log_ready = 1'b0;

    logic [CNT_W-1:0]   pass_count, fail_count, active_cycles;
    logic               first_fail_valid, log_valid, log_overflow, conflict;
    logic [TS_W-1:0]    first_fail_ts, log_ts;
    logic [1:0]         status;

    logic [SMALL_W-1:0] s_pass_count, s_fail_count, s_active_cycles;
    logic               s_ffv, s_log_valid, s_log_overflow, s_conflict;
    logic [TS_W-1:0]    s_ffts, s_log_ts;
    logic [1:0]         s_status;

    assertion_result_collector #(.CNT_W(CNT_W), .TS_W(TS_W), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .assertion_pass(a_pass), .assertion_fail(a_fail), .assertion_active(a_act),
        .pass_count(pass_count), .fail_count(fail_count), .active_cycles(active_cycles),
        .first_fail_valid(first_fail_valid), .first_fail_ts(first_fail_ts),
        .log_valid(log_valid), .log_ts(log_ts), .log_ready(log_ready),
        .log_overflow(log_overflow), .conflict(conflict), .status(status)
    );

    assertion_result_collector #(.CNT_W(SMALL_W), .TS_W(TS_W), .LOG_DEPTH(DEPTH)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .assertion_pass(a_pass), .assertion_fail(a_fail), .assertion_active(a_act),
        .pass_count(s_pass_count), .fail_count(s_fail_count), .active_cycles(s_active_cycles),
        .first_fail_valid(s_ffv), .first_fail_ts(s_ffts),
        .log_valid(s_log_valid), .log_ts(s_log_ts), .log_ready(log_ready),
        .log_overflow(s_log_overflow), .conflict(s_conflict), .status(s_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_pass, m_fail, m_act;
    bit          m_ffv, m_ovf, m_conf;
    logic [31:0] m_ffts, m_ts;
    logic [31:0] m_q[$];
    logic [1:0]  m_st;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    function automatic void model_reset();
        m_pass = 0; m_fail = 0; m_act = 0;
        m_ffv = 0; m_ovf = 0; m_conf = 0;
        m_ffts = '0; m_ts = '0; m_st = 2'b00;
        m_q.delete();
    endfunction

    // Status codes: 0 IDLE, 1 RUN, 2 FAIL, 3 OVFL.
    function automatic void model_step();
        bit p, f, a, pop, ovfev;
        p = enable && a_pass;
        f = enable && a_fail;
        a = enable && a_act;
        if (clear) begin
            m_pass = 0; m_fail = 0; m_act = 0;
            m_ffv = 0; m_ffts = '0; m_ovf = 0; m_conf = 0;
            m_q.delete();
            m_st = enable ? 2'd1 : 2'd0;
        end else begin
            pop = (m_q.size() != 0) && log_ready;
            if (p) m_pass++;
            if (f) m_fail++;
            if (a) m_act++;
            if (p && f) m_conf = 1;
            if (f && !m_ffv) begin
                m_ffv = 1;
                m_ffts = m_ts;
            end
            if (pop) void'(m_q.pop_front());
            ovfev = 0;
            if (f) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else ovfev = 1;
            end
            if (ovfev) begin
                m_ovf = 1;
                m_st = 2'd3;
            end else if (m_st == 2'd0) begin
                if (enable) m_st = 2'd1;
            end else if (m_st == 2'd1) begin
                if (f) m_st = 2'd2;
                else if (!enable) m_st = 2'd0;
            end
        end
        if (enable) m_ts = m_ts + 32'd1;
    endfunction

    task automatic check_all();
        chk("pass_count", 64'(pass_count), sat(m_pass, CNT_W));
        chk("fail_count", 64'(fail_count), sat(m_fail, CNT_W));
        chk("active_cycles", 64'(active_cycles), sat(m_act, CNT_W));
        chk("small_pass_count", 64'(s_pass_count), sat(m_pass, SMALL_W));
        chk("small_fail_count", 64'(s_fail_count), sat(m_fail, SMALL_W));
        chk("small_active_cycles", 64'(s_active_cycles), sat(m_act, SMALL_W));
        chk("first_fail_valid", 64'(first_fail_valid), 64'(m_ffv));
        chk("first_fail_ts", 64'(first_fail_ts), 64'(m_ffts));
        chk("log_valid", 64'(log_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("log_ts", 64'(log_ts), 64'(m_q[0]));
        chk("log_overflow", 64'(log_overflow), 64'(m_ovf));
        chk("conflict", 64'(conflict), 64'(m_conf));
        chk("status", 64'(status), 64'(m_st));
    endtask

    task automatic drive(input bit en, input bit clr, input bit p, input bit f, input bit a, input bit rdy);
        enable = en; clear = clr; a_pass = p; a_fail = f; a_act = a; log_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asserts rst_n between edges and expects outputs to drop without waiting for a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_all();

        repeat (10) drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, (i == 2 || i == 6 || i == 9), 0, 0);
        repeat (5) drive(1, 0, 0, 0, 0, 1);

        drive(1, 1, 0, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 1, 0, 0);

        drive(1, 1, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 1);

        drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0, 0);

        repeat (20) drive(1, 0, 1, 0, 1, 0);
        repeat (3) drive(0, 0, 1, 1, 1, 0);
        drive(1, 0, 0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 1);

        repeat (3) drive(1, 0, 0, 1, 0, 0);
        async_reset();
        repeat (3) drive(1, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
